sysid_regbank: RTL and testbench
================================

Name: sysid_regbank

Overview:
- Parametrised successor to the fixed two-word system-ID slave.
- Avalon-MM register bank on the control bus:
  - read-only ID, timestamp and capability words;
  - free-running 64-bit uptime counter with coherent high-word snapshot;
  - sticky wrap flag;
  - NUM_SCRATCH read/write scratch words for software handshakes.
- Fixed read latency of 1 cycle; sits on the processor's control interconnect.

Parameters:
- SYSTEM_ID, 32'h0000_000B, value returned at word 0.
- TIMESTAMP, 32'd1447576925, value returned at word 1.
- ADDR_W, 4, word-address width. Must be >= 4.
- NUM_SCRATCH, 4, number of scratch words at word 8 upward. Must satisfy 0..2^ADDR_W-8; elaboration error otherwise.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high exactly one cycle after an accepted read.
- irq  out  1  present only with SYSID_IRQ_EN.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. All registers clear on the clock edge with reset=1:
  - readdata=0, readdatavalid=0, scratch=0, uptime=0, shadow=0, wrap=0;
  - CTRL.run=1, CTRL.irq_en=0.
- Address map (word):
  - 0 ID (RO);
  - 1 TIMESTAMP (RO);
  - 2 CAPS (RO): [7:0]=NUM_SCRATCH, [8]=1 if SYSID_IRQ_EN, others 0;
  - 3 CTRL: [0] run (RW), [1] clear (W1, reads 0), [2] wrap (RO sticky, W1C), [3] irq_en (RW);
  - 4 UPTIME_LO;
  - 5 UPTIME_HI snapshot;
  - 6,7 reserved, read 0;
  - 8..8+NUM_SCRATCH-1 scratch.
- Read: read=1 at cycle N -> readdata and readdatavalid=1 at N+1.
  - readdata holds its value when no read occurs; readdatavalid is a one-cycle pulse.
  - Out-of-range addresses read 0. Back-to-back reads are allowed every cycle.
- Write: takes effect at the next edge.
  - Writes to RO or reserved addresses are ignored.
  - Scratch writes honour byteenable per lane. CTRL uses lane 0 only.
- Read and write in the same cycle to the same address: readdata returns the pre-write value.
- Uptime counter: increments by 1 each cycle while run=1 and holds while run=0.
  - Clear write zeroes it at the next edge. Clear beats increment.
  - Wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 sets wrap.
  - Wrap set in the same cycle as a W1C: set wins.
- Snapshot:
  - Reading word 4 returns counter[31:0] as sampled in the request cycle.
  - The same edge loads shadow <= counter[63:32] from that same sample.
  - Reading word 5 returns shadow and never the live high word.
- Reset asserted mid-read: readdatavalid=0 on the following cycle and the read is dropped.

Optional Feature:
- SYSID_IRQ_EN defined:
  - irq port exists; irq = registered (wrap & irq_en). It asserts 1 cycle after wrap sets and deasserts 1 cycle after the wrap W1C.
  - CAPS[8]=1.
- Undefined:
  - no irq port; CTRL[3] reads 0 and writes to it are ignored; CAPS[8]=0.

Decomposition:
- sysid_pkg holds:
  - address localparams (ADR_ID=0 … ADR_SCRATCH0=8);
  - CTRL bit indices;
  - CAPS field positions.
- One sub-module, sysid_uptime_counter, contains:
  - 64-bit counter, run/clear/wrap logic and shadow register;
  - ports: clock, reset, run, clear, wrap_clr, snap, count_lo, shadow_hi, wrap.
- The top level holds address decode, scratch array and read mux.

Test Plan:
- Reset, then read words 0,1,2 (NUM_SCRATCH=4) -> 32'h0000000B, 32'd1447576925, 32'h0000000n with n=4 (+bit 8 if SYSID_IRQ_EN); each readdatavalid exactly 1 cycle after read.
- Write 32'hA5A5_1234 with byteenable=4'b0101 to word 9 after reset, then read -> 32'h00A5_0034; write to word 0, then read -> still SYSID_ID.
- Clear the counter, then let it run 100 cycles, read word 4 then word 5 -> low within 100+access latency, high=0. Write CTRL.run=0, read word 4 twice -> identical values.
- Force the counter to 64'hFFFF_FFFF_FFFF_FFFE via a bench hierarchical deposit; after 2 cycles wrap=1 (CTRL reads bit 2 set). Write 32'h4 to CTRL -> wrap=0. With SYSID_IRQ_EN and irq_en=1, irq rises 1 cycle after wrap and falls 1 cycle after clear.
- Hold the counter hi=0 and cross 32'hFFFF_FFFF during a word-4 read -> the shadow hi matches the sampled low (coherent 0/FFFFFFFF or 1/00000000, never mixed).
- Assert reset in the cycle after a read -> readdatavalid=0, readdata=0; scratch and CTRL return to reset values.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared address map, CTRL bit positions and CAPS field layout for the sysid_regbank slave.
package sysid_pkg;

  localparam int unsigned ADR_ID        = 0;
  localparam int unsigned ADR_TIMESTAMP = 1;
  localparam int unsigned ADR_CAPS      = 2;
  localparam int unsigned ADR_CTRL      = 3;
  localparam int unsigned ADR_UPTIME_LO = 4;
  localparam int unsigned ADR_UPTIME_HI = 5;
  localparam int unsigned ADR_SCRATCH0  = 8;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_WRAP   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned CAPS_NSCR_LSB = 0;
  localparam int unsigned CAPS_NSCR_W   = 8;
  localparam int unsigned CAPS_IRQ      = 8;

endpackage

// File: rtl/sysid_uptime_counter.sv
// 64-bit free-running uptime counter with sticky wrap flag and a high-word shadow
// that is loaded from the same sample the low word is read from.
module sysid_uptime_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        wrap_clr,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] shadow_hi,
  output logic        wrap
);

  logic [63:0] count;
  logic        wrap_set;

  // A clear pre-empts the increment, so a cleared all-ones count is not a wrap.
  assign wrap_set = run && !clear && (count == '1);
  assign count_lo = count[31:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      shadow_hi <= '0;
      wrap      <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (run) begin
        count <= count + 64'd1;
      end
      if (snap) begin
        shadow_hi <= count[63:32];
      end
      if (wrap_set) begin
        wrap <= 1'b1;
      end else if (wrap_clr) begin
        wrap <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sysid_regbank.sv
// Avalon-MM system-ID register bank: ID/timestamp/caps, uptime counter, CTRL and scratch words.
// Optional interrupt output is enabled by defining SYSID_IRQ_EN.
module sysid_regbank
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_000B,
  parameter logic [31:0] TIMESTAMP   = 32'd1447576925,
  parameter int          ADDR_W      = 4,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
`ifdef SYSID_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  if (ADDR_W < 4 || NUM_SCRATCH < 0 || NUM_SCRATCH > (1 << ADDR_W) - 8) begin : g_bad_cfg
    $error("sysid_regbank: ADDR_W must be >= 4 and NUM_SCRATCH within 0..2**ADDR_W-8");
  end

  logic        run;
  logic        irq_en;
  logic        ctrl_wr;
  logic        clear;
  logic        wrap_clr;
  logic        snap;
  logic        wrap;
  logic [31:0] count_lo;
  logic [31:0] shadow_hi;
  logic [31:0] rdata_p0;
  logic [31:0] scratch [SCR_N];

  assign ctrl_wr  = write && (address == ADDR_W'(ADR_CTRL)) && byteenable[0];
  assign clear    = ctrl_wr && writedata[CTRL_CLEAR];
  assign wrap_clr = ctrl_wr && writedata[CTRL_WRAP];
  assign snap     = read && (address == ADDR_W'(ADR_UPTIME_LO));

  sysid_uptime_counter u_uptime (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .wrap_clr  (wrap_clr),
    .snap      (snap),
    .count_lo  (count_lo),
    .shadow_hi (shadow_hi),
    .wrap      (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      run <= 1'b1;
    end else if (ctrl_wr) begin
      run <= writedata[CTRL_RUN];
    end
  end

`ifdef SYSID_IRQ_EN
  localparam logic IRQ_CAP = 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      irq <= wrap && irq_en;
    end
  end
`else
  localparam logic IRQ_CAP = 1'b0;

  assign irq_en = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SCR_N; i++) begin
        scratch[i] <= '0;
      end
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == ADDR_W'(ADR_SCRATCH0 + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
              scratch[i][8*b +: 8] <= writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Stage p0: combinational read mux on the request-cycle state.
  always_comb begin
    rdata_p0 = '0;
    case (address)
      ADDR_W'(ADR_ID):        rdata_p0 = SYSTEM_ID;
      ADDR_W'(ADR_TIMESTAMP): rdata_p0 = TIMESTAMP;
      ADDR_W'(ADR_CAPS): begin
        rdata_p0[CAPS_NSCR_LSB +: CAPS_NSCR_W] = 8'(NUM_SCRATCH);
        rdata_p0[CAPS_IRQ]                     = IRQ_CAP;
      end
      ADDR_W'(ADR_CTRL): begin
        rdata_p0[CTRL_RUN]    = run;
        rdata_p0[CTRL_WRAP]   = wrap;
        rdata_p0[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_W'(ADR_UPTIME_LO): rdata_p0 = count_lo;
      ADDR_W'(ADR_UPTIME_HI): rdata_p0 = shadow_hi;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == ADDR_W'(ADR_SCRATCH0 + i)) begin
            rdata_p0 = scratch[i];
          end
        end
      end
    endcase
  end

  // Stage p1: registered read response.
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_sysid_regbank.sv
// Directed bench for sysid_regbank; define SYSID_IRQ_EN to also exercise the irq output.
module tb_sysid_regbank;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
`ifdef SYSID_IRQ_EN
  logic        irq;
  localparam logic [31:0] CAPS_EXP = 32'h0000_0104;
  localparam logic [31:0] IRQ_BIT  = 32'h0000_0008;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0000_0004;
  localparam logic [31:0] IRQ_BIT  = 32'h0000_0000;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sysid_regbank dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
`ifdef SYSID_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, "_vld"}, {31'b0, readdatavalid}, 32'd1);
    d    = readdata;
    read = 1'b0;
    @(posedge clock);
    #1;
    chk({tag, "_vld_pulse"}, {31'b0, readdatavalid}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(posedge clock);
    #1;
    write = 1'b0;
  endtask

  logic [31:0] v, v2;

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_vld", {31'b0, readdatavalid}, 32'h0);
    reset = 1'b0;

    rd("id", 4'd0, v);        chk("id", v, 32'h0000_000B);
    rd("timestamp", 4'd1, v); chk("timestamp", v, 32'd1447576925);
    rd("caps", 4'd2, v);      chk("caps", v, CAPS_EXP);
    rd("ctrl_rst", 4'd3, v);  chk("ctrl_rst", v, 32'h1);
    rd("scr8_rst", 4'd8, v);  chk("scr8_rst", v, 32'h0);

    wr(4'd9, 32'hA5A5_1234, 4'b0101);
    rd("scr9_be", 4'd9, v);   chk("scr9_be", v, 32'h00A5_0034);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd("id_ro", 4'd0, v);     chk("id_ro", v, 32'h0000_000B);
    wr(4'd6, 32'h1234_5678, 4'hF);
    rd("rsvd6", 4'd6, v);     chk("rsvd6", v, 32'h0);
    rd("oor15", 4'd15, v);    chk("oor15", v, 32'h0);

    // Read and write to the same scratch word in one cycle.
    address = 4'd10; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
    chk("rw_same_old", readdata, 32'h0);
    rd("rw_same_new", 4'd10, v); chk("rw_same_new", v, 32'hDEAD_BEEF);

    wr(4'd3, 32'h3, 4'h1);
    repeat (100) @(posedge clock);
    #1;
    rd("up_lo", 4'd4, v);
    chk("up_lo_range", {31'b0, (v >= 32'd100 && v <= 32'd102)}, 32'd1);
    rd("up_hi", 4'd5, v);     chk("up_hi", v, 32'h0);

    wr(4'd3, 32'h0, 4'h1);
    rd("hold_a", 4'd4, v);
    rd("hold_b", 4'd4, v2);
    chk("hold_equal", v2, v);
    rd("ctrl_stopped", 4'd3, v2); chk("ctrl_stopped", v2, 32'h0);

    // Wrap: run (plus irq_en when present), force the count near all-ones.
    wr(4'd3, 32'h1 | IRQ_BIT, 4'h1);
    dut.u_uptime.count = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
`ifdef SYSID_IRQ_EN
    chk("irq_not_yet", {31'b0, irq}, 32'h0);
    @(posedge clock);
    #1;
    chk("irq_rise", {31'b0, irq}, 32'h1);
`endif
    rd("ctrl_wrap", 4'd3, v); chk("ctrl_wrap", v, 32'h5 | IRQ_BIT);
    wr(4'd3, 32'h5 | IRQ_BIT, 4'h1);
`ifdef SYSID_IRQ_EN
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(posedge clock);
    #1;
    chk("irq_fall", {31'b0, irq}, 32'h0);
`endif
    rd("ctrl_w1c", 4'd3, v);  chk("ctrl_w1c", v, 32'h1 | IRQ_BIT);

    // Coherent snapshot on both sides of the low-word rollover.
    dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
    rd("snap_a_lo", 4'd4, v); chk("snap_a_lo", v, 32'hFFFF_FFFF);
    rd("snap_a_hi", 4'd5, v); chk("snap_a_hi", v, 32'h0);
    dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
    @(posedge clock);
    #1;
    rd("snap_b_lo", 4'd4, v); chk("snap_b_lo", v, 32'h0);
    rd("snap_b_hi", 4'd5, v); chk("snap_b_hi", v, 32'h1);

    // Reset coincident with a read drops the read.
    wr(4'd3, 32'h0 | IRQ_BIT, 4'h1);
    address = 4'd9; read = 1'b1; reset = 1'b1;
    @(posedge clock);
    #1;
    read = 1'b0; reset = 1'b0;
    chk("rst_read_vld", {31'b0, readdatavalid}, 32'h0);
    chk("rst_read_data", readdata, 32'h0);
`ifdef SYSID_IRQ_EN
    chk("rst_irq", {31'b0, irq}, 32'h0);
`endif
    rd("scr9_rst", 4'd9, v);   chk("scr9_rst", v, 32'h0);
    rd("scr10_rst", 4'd10, v); chk("scr10_rst", v, 32'h0);
    rd("ctrl_rst2", 4'd3, v);  chk("ctrl_rst2", v, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
